// File: rtl/keypad_hex_entry.sv
// keypad_hex_entry: 4x4 active-low matrix keypad scanner with debounced
// hex-digit entry into a 32-bit shift register (newest digit in Data[3:0]).
// Optional build macro KEYPAD_AUTOREPEAT_EN adds auto-repeat while a key is
// held; without it a held key is accepted exactly once.
module keypad_hex_entry #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned REPEAT_FRAMES  = 32
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic [3:0]  Col,
  input  logic        Clr,
  output logic [3:0]  Row,
  output logic [31:0] Data,
  output logic [3:0]  Key_Code,
  output logic        Key_Valid,
  output logic [3:0]  Digit_Cnt
);

  localparam logic [15:0] PrescLast = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  DebLast   = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_t;

  logic [3:0]  col_s1_q, col_s2_q;
  logic [15:0] presc_q;
  logic [1:0]  row_idx_q;
  logic [3:0]  row_drv_q;

  logic        acc_seen_q, acc_multi_q;
  logic [3:0]  acc_key_q;

  state_t      state_q;
  logic [3:0]  cand_q;
  logic [3:0]  cnt_q;

  logic [31:0] data_q;
  logic [3:0]  code_q;
  logic        valid_q;
  logic [3:0]  dcnt_q;

  logic        tick, frame_end;
  logic        samp_none, samp_one, samp_bad;
  logic [1:0]  samp_col;
  logic        frm_multi, frm_single, frm_none, frm_match;
  logic [3:0]  frm_key;
  logic [3:0]  cnt_inc;
  logic        deb_accept, rpt_fire, accept;

  // Two-flop synchronizer for the asynchronous column returns
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      col_s1_q <= '1;
      col_s2_q <= '1;
    end else begin
      col_s1_q <= Col;
      col_s2_q <= col_s1_q;
    end
  end

  assign tick      = (presc_q == PrescLast);
  assign frame_end = tick && (row_idx_q == 2'd3);

  // Row-step prescaler, wraps at SCAN_DIV-1
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 16'd1;
    end
  end

  // Row index and registered active-low one-hot row drive
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      row_idx_q <= '0;
      row_drv_q <= 4'b0111;
    end else if (tick) begin
      row_idx_q <= row_idx_q + 2'd1;
      case (row_idx_q)
        2'd0:    row_drv_q <= 4'b1011;
        2'd1:    row_drv_q <= 4'b1101;
        2'd2:    row_drv_q <= 4'b1110;
        default: row_drv_q <= 4'b0111;
      endcase
    end
  end

  assign Row = row_drv_q;

  // Classify the synchronized sample of the row currently driven
  always_comb begin
    samp_one = 1'b1;
    samp_col = 2'd0;
    case (col_s2_q)
      4'b0111: samp_col = 2'd0;
      4'b1011: samp_col = 2'd1;
      4'b1101: samp_col = 2'd2;
      4'b1110: samp_col = 2'd3;
      default: samp_one = 1'b0;
    endcase
  end

  assign samp_none = (col_s2_q == 4'b1111);
  assign samp_bad  = !samp_none && !samp_one;

  // Frame result: accumulated rows 0..2 merged with the row-3 sample being taken now
  assign frm_multi  = acc_multi_q || samp_bad || (acc_seen_q && samp_one);
  assign frm_single = !frm_multi && (acc_seen_q || samp_one);
  assign frm_none   = !frm_multi && !frm_single;
  assign frm_key    = samp_one ? {row_idx_q, samp_col} : acc_key_q;
  assign frm_match  = frm_single && (frm_key == cand_q);
  assign cnt_inc    = cnt_q + 4'd1;

  // Per-frame accumulation of row samples, restarted at every frame end
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      acc_seen_q  <= 1'b0;
      acc_multi_q <= 1'b0;
      acc_key_q   <= '0;
    end else if (frame_end) begin
      acc_seen_q  <= 1'b0;
      acc_multi_q <= 1'b0;
      acc_key_q   <= '0;
    end else if (tick) begin
      if (samp_bad) begin
        acc_multi_q <= 1'b1;
      end
      if (samp_one) begin
        if (acc_seen_q) begin
          acc_multi_q <= 1'b1;
        end else begin
          acc_seen_q <= 1'b1;
          acc_key_q  <= {row_idx_q, samp_col};
        end
      end
    end
  end

  assign deb_accept = frame_end && (state_q == ST_DEBOUNCE) && frm_match &&
                      (cnt_inc == DebLast);
  assign accept     = deb_accept || rpt_fire;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [7:0] RptLast = 8'(REPEAT_FRAMES);

  logic [7:0] rpt_q;
  logic [7:0] rpt_inc;

  assign rpt_inc  = rpt_q + 8'd1;
  assign rpt_fire = frame_end && (state_q == ST_HELD) && frm_match &&
                    (rpt_inc == RptLast);

  // Repeat counter: consecutive SINGLE(cand) frames while held
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      rpt_q <= '0;
    end else if (frame_end) begin
      if (state_q == ST_HELD && frm_match) begin
        rpt_q <= (rpt_inc == RptLast) ? 8'd0 : rpt_inc;
      end else begin
        rpt_q <= '0;
      end
    end
  end
`else
  // REPEAT_FRAMES has no effect in this build; the compare keeps it referenced
  assign rpt_fire = (REPEAT_FRAMES == 0) && 1'b0;
`endif

  // Debounce / hold / release state machine, stepped once per frame
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= ST_IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
    end else if (frame_end) begin
      case (state_q)
        ST_IDLE: begin
          if (frm_single) begin
            state_q <= ST_DEBOUNCE;
            cand_q  <= frm_key;
            cnt_q   <= 4'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (frm_match) begin
            if (cnt_inc == DebLast) begin
              state_q <= ST_HELD;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end else begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end
        end
        ST_HELD: begin
          if (frm_none) begin
            state_q <= ST_RELEASE;
            cnt_q   <= 4'd1;
          end
        end
        default: begin
          if (frm_none) begin
            if (cnt_inc == DebLast) begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end else begin
            state_q <= ST_HELD;
            cnt_q   <= '0;
          end
        end
      endcase
    end
  end

  // Accept strobe and key code; Clr never touches these
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      valid_q <= 1'b0;
      code_q  <= '0;
    end else begin
      valid_q <= accept;
      if (accept) begin
        code_q <= cand_q;
      end
    end
  end

  // Entry register and digit count; Clr takes priority over an accept
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      data_q <= '0;
      dcnt_q <= '0;
    end else if (Clr) begin
      data_q <= '0;
      dcnt_q <= '0;
    end else if (accept) begin
      data_q <= {data_q[27:0], cand_q};
      dcnt_q <= (dcnt_q == 4'd8) ? 4'd8 : dcnt_q + 4'd1;
    end
  end

  assign Data      = data_q;
  assign Key_Code  = code_q;
  assign Key_Valid = valid_q;
  assign Digit_Cnt = dcnt_q;

endmodule

// File: tb/tb_keypad_hex_entry.sv
// tb_keypad_hex_entry: directed bench for keypad_hex_entry with
// SCAN_DIV=4 and DEBOUNCE_SCANS=3 (one frame = 16 clocks).
module tb_keypad_hex_entry;

  logic        CLK = 1'b0;
  logic        RST_n = 1'b0;
  logic        Clr = 1'b0;
  logic [3:0]  Col;
  logic [3:0]  Row;
  logic [31:0] Data;
  logic [3:0]  Key_Code;
  logic        Key_Valid;
  logic [3:0]  Digit_Cnt;

  // Bit k set means the key with code k is pressed
  logic [15:0] keys = '0;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc;
  int pulses = 0;
  int last_pulse = -1;
  logic [3:0] last_code = '0;
  int p0;

  logic [3:0] rowtab [4];

  keypad_hex_entry #(
    .SCAN_DIV(4),
    .DEBOUNCE_SCANS(3),
    .REPEAT_FRAMES(8)
  ) dut (
    .CLK(CLK),
    .RST_n(RST_n),
    .Col(Col),
    .Clr(Clr),
    .Row(Row),
    .Data(Data),
    .Key_Code(Key_Code),
    .Key_Valid(Key_Valid),
    .Digit_Cnt(Digit_Cnt)
  );

  always #5 CLK = ~CLK;

  // Keypad matrix: a pressed key pulls its column low while its row is driven
  always_comb begin
    Col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !Row[3-r]) Col[3-c] = 1'b0;
      end
    end
  end

  // Edge count since reset release
  always @(posedge CLK or negedge RST_n) begin
    if (!RST_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Record every Key_Valid pulse
  always @(negedge CLK) begin
    if (RST_n && Key_Valid) begin
      pulses     = pulses + 1;
      last_pulse = cyc;
      last_code  = Key_Code;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Wait for the negedge following a frame-end edge (Row 1110 -> 0111)
  task automatic wait_frame_end();
    logic [3:0] prev;
    bit done;
    done = 1'b0;
    prev = Row;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge CLK);
      if (prev == 4'b1110 && Row == 4'b0111) done = 1'b1;
      prev = Row;
    end
    chk("frame_end_seen", 32'(done), 32'd1);
  endtask

  task automatic hold(input logic [15:0] m, input int n);
    keys = m;
    repeat (n) wait_frame_end();
  endtask

  initial begin
    rowtab[0] = 4'b0111;
    rowtab[1] = 4'b1011;
    rowtab[2] = 4'b1101;
    rowtab[3] = 4'b1110;

    // Reset values and row stepping
    repeat (3) @(negedge CLK);
    RST_n = 1'b1;
    chk("rst_row", 32'(Row), 32'h7);
    chk("rst_data", Data, 32'h0);
    chk("rst_dcnt", 32'(Digit_Cnt), 32'h0);
    chk("rst_valid", 32'(Key_Valid), 32'h0);
    chk("rst_code", 32'(Key_Code), 32'h0);
    for (int k = 1; k <= 16; k++) begin
      @(negedge CLK);
      chk("row_step", 32'(Row), 32'(rowtab[(k/4)%4]));
    end

    // Key 6 held 10 frames from cycle 16: one pulse at end of 3rd frame (cycle 64)
    p0 = pulses;
    hold(16'h0040, 10);
    chk("hold_pulses", 32'(pulses - p0), 32'd1);
    chk("hold_cycle", 32'(last_pulse), 32'd64);
    chk("hold_code", 32'(last_code), 32'h6);
    chk("hold_data", Data, 32'h0000_0006);
    chk("hold_dcnt", 32'(Digit_Cnt), 32'd1);
    hold(16'h0000, 4);

    // Digits 1..9 with clean releases
    p0 = pulses;
    for (int k = 1; k <= 9; k++) begin
      hold(16'(1 << k), 4);
      hold(16'h0000, 4);
    end
    chk("seq_pulses", 32'(pulses - p0), 32'd9);
    chk("seq_data", Data, 32'h2345_6789);
    chk("seq_dcnt", 32'(Digit_Cnt), 32'd8);
    chk("seq_code", 32'(Key_Code), 32'h9);

    // Bounce: present 2, absent 1, present 2, absent 5 frames
    p0 = pulses;
    hold(16'h0020, 2);
    hold(16'h0000, 1);
    hold(16'h0020, 2);
    hold(16'h0000, 5);
    chk("bounce_pulses", 32'(pulses - p0), 32'd0);
    chk("bounce_data", Data, 32'h2345_6789);

    // Keys 0x3 and 0xC together: MULTI every frame
    p0 = pulses;
    hold(16'h1008, 6);
    hold(16'h0000, 4);
    chk("multi_pulses", 32'(pulses - p0), 32'd0);
    chk("multi_dcnt", 32'(Digit_Cnt), 32'd8);

    // Clr coincident with the accept of key 0xA (48 clocks after frame-aligned press)
    p0 = pulses;
    keys = 16'h0400;
    repeat (47) @(negedge CLK);
    Clr = 1'b1;
    @(negedge CLK);
    Clr = 1'b0;
    chk("clr_valid", 32'(Key_Valid), 32'd1);
    chk("clr_code", 32'(Key_Code), 32'hA);
    chk("clr_data", Data, 32'h0);
    chk("clr_dcnt", 32'(Digit_Cnt), 32'd0);
    hold(16'h0400, 3);
    hold(16'h0000, 4);
    chk("clr_pulses", 32'(pulses - p0), 32'd1);
    chk("clr_data_after", Data, 32'h0);

    // Reset during DEBOUNCE of key 0xB, key kept pressed through reset
    keys = 16'h0800;
    wait_frame_end();
    wait_frame_end();
    @(negedge CLK);
    RST_n = 1'b0;
    repeat (3) @(negedge CLK);
    RST_n = 1'b1;
    p0 = pulses;
    chk("rst2_data", Data, 32'h0);
    chk("rst2_code", 32'(Key_Code), 32'h0);
    repeat (5) wait_frame_end();
    chk("rst2_pulses", 32'(pulses - p0), 32'd1);
    chk("rst2_cycle", 32'(last_pulse), 32'd48);
    chk("rst2_keycode", 32'(last_code), 32'hB);
    chk("rst2_data_after", Data, 32'h0000_000B);
    chk("rst2_dcnt", 32'(Digit_Cnt), 32'd1);
    hold(16'h0000, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
